// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 scan code receiver that tracks the held key as an 8-bit HID usage code.
// Covers W/A/S/D, space, enter and the four arrow keys.
//
// state    | meaning
// S_IDLE   | waiting for a start bit on a filtered falling edge
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking the stop bit and parity, then releasing the byte
module ps2_keycode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          flt_q, flt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fall_edge;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          byte_stb_q, byte_stb_d;
    logic          frame_err_q, frame_err_d;
    logic          tmo_q, tmo_d;

    logic [7:0]    key_q, key_d;
    logic          kv_q, kv_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [7:0]    hid;

    // Glitch filter: the filtered clock only moves after FILTER_LEN
    // consecutive synchronized samples disagree with it.
    always_comb begin
        flt_d     = flt_q;
        flt_cnt_d = '0;
        if (clk_s2_q != flt_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                flt_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FW'(1);
            end
        end
    end

    assign fall_edge = flt_q & ~flt_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        tmo_cnt_d   = tmo_cnt_q;
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;
        tmo_d       = 1'b0;

        if (fall_edge) begin
            tmo_cnt_d = TW'(TIMEOUT_CYCLES - 1);
        end else if (tmo_cnt_q != '0) begin
            tmo_cnt_d = tmo_cnt_q - TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (fall_edge && !dat_s2_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall_edge) begin
                    shreg_d   = {dat_s2_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall_edge) begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall_edge) begin
                    if (dat_s2_q && (^{shreg_q, par_q})) begin
                        byte_stb_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Terminal count with no edge mid-frame: abandon the frame.
        if (state_q != S_IDLE && !fall_edge && tmo_cnt_q == '0) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            tmo_d       = 1'b1;
        end
    end

    always_comb begin
        hid = 8'h00;
        case ({ext_q, shreg_q})
            {1'b0, 8'h1D}: hid = 8'h1A;
            {1'b0, 8'h1C}: hid = 8'h04;
            {1'b0, 8'h1B}: hid = 8'h16;
            {1'b0, 8'h23}: hid = 8'h07;
            {1'b0, 8'h29}: hid = 8'h2C;
            {1'b0, 8'h5A}: hid = 8'h28;
            {1'b1, 8'h75}: hid = 8'h52;
            {1'b1, 8'h6B}: hid = 8'h50;
            {1'b1, 8'h72}: hid = 8'h51;
            {1'b1, 8'h74}: hid = 8'h4F;
            default:       hid = 8'h00;
        endcase
    end

    // hid == 0 marks an unmapped code; such bytes only clear the prefixes.
    always_comb begin
        key_d = key_q;
        kv_d  = 1'b0;
        brk_d = brk_q;
        ext_d = ext_q;
        if (tmo_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (byte_stb_q) begin
            case (shreg_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'hAA, 8'hFA, 8'hFE, 8'hEE: begin
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
                default: begin
                    if (hid != 8'h00) begin
                        if (!brk_q) begin
                            if (hid != key_q) begin
                                key_d = hid;
                                kv_d  = 1'b1;
                            end
                        end else if (hid == key_q) begin
                            key_d = 8'h00;
                            kv_d  = 1'b1;
                        end
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            flt_q       <= 1'b1;
            flt_cnt_q   <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            par_q       <= 1'b0;
            tmo_cnt_q   <= '0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tmo_q       <= 1'b0;
            key_q       <= 8'h00;
            kv_q        <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            flt_q       <= flt_d;
            flt_cnt_q   <= flt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            tmo_cnt_q   <= tmo_cnt_d;
            byte_stb_q  <= byte_stb_d;
            frame_err_q <= frame_err_d;
            tmo_q       <= tmo_d;
            key_q       <= key_d;
            kv_q        <= kv_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
        end
    end

    assign keycode   = key_q;
    assign key_valid = kv_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: directed scenarios plus random scan-code traffic
// compared against a byte-level keyboard model.
module tb_ps2_keycode_rx;

    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] keycode;
    logic       key_valid;
    logic       frame_err;

    ps2_keycode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(200)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .ps2_clk   (ps2c),
        .ps2_data  (ps2d),
        .keycode   (keycode),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    int kv_cnt = 0, fe_cnt = 0, kv_run = 0, kv_long = 0, both_cnt = 0;

    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt++;
            kv_run++;
            if (kv_run == 2) kv_long++;
        end else begin
            kv_run = 0;
        end
        if (frame_err) fe_cnt++;
        if (key_valid && frame_err) both_cnt++;
    end

    logic [7:0] mkey = 8'h00;
    bit         mbrk = 1'b0;
    bit         mext = 1'b0;
    int         exp_kv = 0;
    int         exp_fe = 0;
    int         hid_map[int];

    task automatic model_byte(input logic [7:0] b);
        int key;
        if (b == 8'hE0) mext = 1'b1;
        else if (b == 8'hF0) mbrk = 1'b1;
        else if (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE) begin
            mbrk = 1'b0;
            mext = 1'b0;
        end else begin
            key = (mext ? 256 : 0) + int'(b);
            if (hid_map.exists(key)) begin
                if (!mbrk && hid_map[key] != int'(mkey)) begin
                    mkey = 8'(hid_map[key]);
                    exp_kv++;
                end else if (mbrk && hid_map[key] == int'(mkey)) begin
                    mkey = 8'h00;
                    exp_kv++;
                end
            end
            mbrk = 1'b0;
            mext = 1'b0;
        end
    endtask

    task automatic send_bit(input bit v, input bit glitch);
        ps2d = v;
        repeat (H / 2) @(posedge clk);
        if (glitch) begin
            ps2c = 1'b0;
            @(posedge clk);
            ps2c = 1'b1;
        end
        repeat (H / 2) @(posedge clk);
        ps2c = 1'b0;
        repeat (H / 2) @(posedge clk);
        if (glitch) begin
            ps2c = 1'b1;
            @(posedge clk);
            ps2c = 1'b0;
        end
        repeat (H / 2) @(posedge clk);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i], glitch);
        ps2d = 1'b1;
    endtask

    task automatic check_state(input string tag);
        repeat (2 * H) @(posedge clk);
        @(negedge clk);
        chk({tag, "_key"}, {24'h0, keycode}, {24'h0, mkey});
        chk({tag, "_kv"}, kv_cnt, exp_kv);
        chk({tag, "_fe"}, fe_cnt, exp_fe);
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bad, input bit glitch, input string tag);
        send_frame(b, bad, 11, glitch);
        if (bad) exp_fe++;
        else model_byte(b);
        check_state(tag);
    endtask

    logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29,
                              8'h5A, 8'h75, 8'h6B, 8'h72, 8'h74, 8'hAA, 8'hFA};

    initial begin
        logic [7:0] b;
        bit bad;

        hid_map[32'h01D] = 8'h1A; hid_map[32'h01C] = 8'h04; hid_map[32'h01B] = 8'h16;
        hid_map[32'h023] = 8'h07; hid_map[32'h029] = 8'h2C; hid_map[32'h05A] = 8'h28;
        hid_map[32'h175] = 8'h52; hid_map[32'h16B] = 8'h50;
        hid_map[32'h172] = 8'h51; hid_map[32'h174] = 8'h4F;

        rst  = 1'b1;
        ps2c = 1'b1;
        ps2d = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_key", {24'h0, keycode}, 32'h0);
        chk("rst_kv", {31'h0, key_valid}, 32'h0);
        chk("rst_fe", {31'h0, frame_err}, 32'h0);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("idle_kv", kv_cnt, 0);
        chk("idle_fe", fe_cnt, 0);

        do_frame(8'h1D, 0, 0, "w_make");
        chk("w_key_direct", {24'h0, keycode}, 32'h1A);
        do_frame(8'h1D, 0, 0, "w_repeat");
        do_frame(8'hF0, 0, 0, "w_brk_pre");
        do_frame(8'h1D, 0, 0, "w_brk");
        chk("w_brk_direct", {24'h0, keycode}, 32'h00);

        do_frame(8'hE0, 0, 0, "up_e0");
        do_frame(8'h75, 0, 0, "up_make");
        do_frame(8'h1C, 0, 0, "a_make");
        do_frame(8'hE0, 0, 0, "upb_e0");
        do_frame(8'hF0, 0, 0, "upb_f0");
        do_frame(8'h75, 0, 0, "upb_75");

        do_frame(8'h23, 1, 0, "d_badpar");
        do_frame(8'hF0, 0, 0, "brk_keep_f0");
        do_frame(8'h12, 1, 0, "brk_keep_bad");
        do_frame(8'h23, 0, 0, "brk_keep_23");

        send_frame(8'h1D, 0, 5, 0);
        repeat (300) @(posedge clk);
        exp_fe++;
        mbrk = 1'b0;
        mext = 1'b0;
        check_state("timeout");
        do_frame(8'h1B, 0, 0, "s_after_tmo");

        do_frame(8'h1C, 0, 1, "glitch_a");

        send_frame(8'h1D, 0, 4, 0);
        @(posedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        mkey = 8'h00;
        mbrk = 1'b0;
        mext = 1'b0;
        repeat (H) @(posedge clk);
        do_frame(8'h1D, 0, 0, "after_rst");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 3) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 13)];
            bad = ($urandom_range(0, 7) == 0);
            do_frame(b, bad, 0, "rand");
        end

        chk("kv_width", kv_long, 0);
        chk("kv_fe_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
